// File: rtl/crc_pkg.sv
// Shared definitions for the CRC engine: FSM encoding, common polynomials and width limits.
package crc_pkg;

    localparam int CRC_W_MIN  = 2;
    localparam int CRC_W_MAX  = 32;
    localparam int DATA_W_MIN = 1;
    localparam int DATA_W_MAX = 32;

    // Polynomials with the implicit x^CRC_W term omitted
    localparam logic [31:0] CRC8_POLY_31     = 32'h0000_0031;
    localparam logic [31:0] CRC8_POLY_07     = 32'h0000_0007;
    localparam logic [31:0] CRC16_CCITT_1021 = 32'h0000_1021;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/crc_step.sv
// Combinational CRC fold: advances a CRC_W-bit LFSR by DATA_W input bits, MSB of din first.
module crc_step
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 8,
    parameter int               DATA_W = 1,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC8_POLY_31)
) (
    input  logic [CRC_W-1:0]  state,
    input  logic [DATA_W-1:0] din,
    output logic [CRC_W-1:0]  next_state
);

    logic [CRC_W-1:0] acc;
    logic             fb;

    always_comb begin
        acc = state;
        fb  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb  = din[i] ^ acc[CRC_W-1];
            acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        next_state = acc;
    end

endmodule

// File: rtl/crc_engine.sv
// Frame-oriented CRC generator: folds DATA_W bits per beat, pulses crc_valid after the last beat.
// Defining CRC_CHECK_EN adds chk_mode/crc_err for residue checking of frames carrying their CRC.
module crc_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 8,
    parameter int               DATA_W  = 1,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC8_POLY_31),
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              din_last,
    output logic              busy,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid,
    output logic [CRC_W-1:0]  crc_state
`ifdef CRC_CHECK_EN
    ,
    input  logic              chk_mode,
    output logic              crc_err
`endif
);

    if (CRC_W < CRC_W_MIN || CRC_W > CRC_W_MAX) begin : g_bad_crc_w
        $error("crc_engine: CRC_W out of range");
    end
    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("crc_engine: DATA_W out of range");
    end

    fsm_state_e       fsm_q;
    fsm_state_e       fsm_d;
    logic [CRC_W-1:0] lfsr_p0;
    logic [CRC_W-1:0] lfsr_d;
    logic [CRC_W-1:0] base;
    logic [CRC_W-1:0] stepped;
    logic             fold;
    logic             finish;
    logic [CRC_W-1:0] result_p1;
    logic             vld_p1;

    // A start restarts from INIT so a same-cycle beat folds onto a fresh register
    assign base = start ? INIT : lfsr_p0;

    crc_step #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_step (
        .state      (base),
        .din        (din),
        .next_state (stepped)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: if (start) fsm_d = finish ? ST_IDLE : ST_RUN;
            ST_RUN:  if (finish) fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (fsm_q == ST_RUN);
        fold   = din_valid && (start || fsm_q == ST_RUN);
        finish = fold && din_last;
        lfsr_d = lfsr_p0;
        if (fold) begin
            lfsr_d = stepped;
        end else if (start) begin
            lfsr_d = INIT;
        end
    end

    // Stage p0: live LFSR register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_p0 <= INIT;
        end else begin
            lfsr_p0 <= lfsr_d;
        end
    end

    // Stage p1: frame result, held until the next completed frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= finish;
            if (finish) begin
                result_p1 <= stepped ^ XOR_OUT;
            end
        end
    end

`ifdef CRC_CHECK_EN
    logic err_p1;

    // A frame that carries its own CRC leaves a zero residue when intact
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_p1 <= 1'b0;
        end else if (finish) begin
            err_p1 <= chk_mode && (stepped != '0);
        end
    end

    assign crc_err = err_p1;
`endif

    assign crc_out   = result_p1;
    assign crc_valid = vld_p1;
    assign crc_state = lfsr_p0;

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine: serial crc8, byte-wide crc8 and CRC-16/CCITT-FALSE instances.
module tb_crc_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic       s_start, s_valid, s_last, s_busy, s_cv;
    logic [0:0] s_din;
    logic [7:0] s_out, s_state;
    logic       b_start, b_valid, b_last, b_busy, b_cv;
    logic [7:0] b_din, b_out, b_state;
    logic       w_start, w_valid, w_last, w_busy, w_cv;
    logic [7:0] w_din;
    logic [15:0] w_out, w_state;
`ifdef CRC_CHECK_EN
    logic b_chk, s_err, b_err, w_err;
`endif

    crc_engine #(.CRC_W(8), .DATA_W(1), .POLY(8'h31), .INIT(8'h00), .XOR_OUT(8'h00)) u_s (
        .clk(clk), .rstn(rstn), .start(s_start), .din(s_din), .din_valid(s_valid),
        .din_last(s_last), .busy(s_busy), .crc_out(s_out), .crc_valid(s_cv), .crc_state(s_state)
`ifdef CRC_CHECK_EN
        , .chk_mode(1'b0), .crc_err(s_err)
`endif
    );

    crc_engine #(.CRC_W(8), .DATA_W(8), .POLY(8'h31), .INIT(8'h00), .XOR_OUT(8'h00)) u_b (
        .clk(clk), .rstn(rstn), .start(b_start), .din(b_din), .din_valid(b_valid),
        .din_last(b_last), .busy(b_busy), .crc_out(b_out), .crc_valid(b_cv), .crc_state(b_state)
`ifdef CRC_CHECK_EN
        , .chk_mode(b_chk), .crc_err(b_err)
`endif
    );

    crc_engine #(.CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000)) u_w (
        .clk(clk), .rstn(rstn), .start(w_start), .din(w_din), .din_valid(w_valid),
        .din_last(w_last), .busy(w_busy), .crc_out(w_out), .crc_valid(w_cv), .crc_state(w_state)
`ifdef CRC_CHECK_EN
        , .chk_mode(1'b0), .crc_err(w_err)
`endif
    );

    typedef struct {
        logic [15:0] crc;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sq[$];
    exp_t bq[$];
    exp_t wq[$];

    typedef struct {
        logic       st;
        logic [7:0] d;
        logic       v;
        logic       l;
        logic       chk;
        logic       want;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[17];

    // Serial bit-at-a-time reference: the crc8 LFSR the engine must reproduce
    function automatic logic [7:0] ref8(input logic [7:0] s, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = s;
        for (int i = 7; i >= 0; i--) begin
            fb = d[i] ^ r[7];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, want);
        end
    endtask

    // One beat on instance k (0 serial, 1 byte, 2 crc16); all other instances are idled
    task automatic drive(input int k, input logic st, input logic [7:0] d, input logic v,
                         input logic l, input logic chkm, input logic [15:0] want_crc,
                         input logic want);
        exp_t e;
        @(posedge clk);
        #1;
        s_start = 0; s_din = '0; s_valid = 0; s_last = 0;
        b_start = 0; b_din = '0; b_valid = 0; b_last = 0;
        w_start = 0; w_din = '0; w_valid = 0; w_last = 0;
`ifdef CRC_CHECK_EN
        b_chk = 0;
`endif
        case (k)
            0: begin s_start = st; s_din = d[0]; s_valid = v; s_last = l; end
            1: begin
                b_start = st; b_din = d; b_valid = v; b_last = l;
`ifdef CRC_CHECK_EN
                b_chk = chkm;
`endif
            end
            default: begin w_start = st; w_din = d; w_valid = v; w_last = l; end
        endcase
        if (want) begin
            e.crc = want_crc;
            e.err = (k == 1) && chkm && (want_crc != 16'h0);
            e.cyc = cyc + 1;
            case (k)
                0: sq.push_back(e);
                1: bq.push_back(e);
                default: wq.push_back(e);
            endcase
        end
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 0, 0, 0, 16'h0, 0);
    endtask

    task automatic mon(input int k, input logic [15:0] out, input logic err);
        exp_t  e;
        logic  have;
        string nm;
        have = 0;
        case (k)
            0: begin nm = "serial8"; if (sq.size() > 0) begin e = sq.pop_front(); have = 1; end end
            1: begin nm = "byte8";   if (bq.size() > 0) begin e = bq.pop_front(); have = 1; end end
            default: begin nm = "crc16"; if (wq.size() > 0) begin e = wq.pop_front(); have = 1; end end
        endcase
        total++;
        if (!have) begin
            bad++;
            $display("FAIL %s unexpected crc_valid: crc_out=%h cycle=%0d", nm, out, cyc);
        end else begin
            if (out !== e.crc || cyc != e.cyc) begin
                bad++;
                $display("FAIL %s result: got crc=%h cycle=%0d want crc=%h cycle=%0d",
                         nm, out, cyc, e.crc, e.cyc);
            end
`ifdef CRC_CHECK_EN
            total++;
            if (err !== e.err) begin
                bad++;
                $display("FAIL %s crc_err: got=%b want=%b", nm, err, e.err);
            end
`else
            if (err !== 1'b0) $display("note: unexpected err input");
`endif
        end
    endtask

    always @(negedge clk) begin
`ifdef CRC_CHECK_EN
        if (s_cv) mon(0, 16'(s_out), s_err);
        if (b_cv) mon(1, 16'(b_out), b_err);
        if (w_cv) mon(2, w_out, w_err);
`else
        if (s_cv) mon(0, 16'(s_out), 1'b0);
        if (b_cv) mon(1, 16'(b_out), 1'b0);
        if (w_cv) mon(2, w_out, 1'b0);
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         n;
        logic [7:0] m;
        logic [7:0] d;
        logic [7:0] msg[9];

        rstn = 0;
        s_start = 0; s_din = '0; s_valid = 0; s_last = 0;
        b_start = 0; b_din = '0; b_valid = 0; b_last = 0;
        w_start = 0; w_din = '0; w_valid = 0; w_last = 0;
`ifdef CRC_CHECK_EN
        b_chk = 0;
`endif
        #12;
        chk("rst_s_busy", 32'(s_busy), 0);   chk("rst_s_out", 32'(s_out), 0);
        chk("rst_s_vld", 32'(s_cv), 0);      chk("rst_s_state", 32'(s_state), 0);
        chk("rst_b_busy", 32'(b_busy), 0);   chk("rst_b_out", 32'(b_out), 0);
        chk("rst_b_vld", 32'(b_cv), 0);      chk("rst_b_state", 32'(b_state), 0);
        chk("rst_w_busy", 32'(w_busy), 0);   chk("rst_w_out", 32'(w_out), 0);
        chk("rst_w_vld", 32'(w_cv), 0);      chk("rst_w_state", 32'(w_state), 32'hFFFF);
        rstn = 1;

        // Serial frame 0x80 bit by bit
        for (int i = 7; i >= 0; i--) begin
            drive(0, i == 7, 8'(i == 7), 1, i == 0, 0, 16'h7A, i == 0);
            if (i == 6) begin
                chk("s_busy_run", 32'(s_busy), 1);
                chk("s_state_first_bit", 32'(s_state), 32'h31);
            end
        end
        idle();
        chk("s_busy_done", 32'(s_busy), 0);
        chk("s_state_final", 32'(s_state), 32'h7A);
        // Beat without start while idle is ignored
        drive(0, 0, 8'h01, 1, 1, 0, 16'h0, 0);
        idle();
        idle();
        chk("s_idle_ignore", 32'(s_state), 32'h7A);
        chk("s_idle_busy", 32'(s_busy), 0);

        tbl[0]  = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 8'h7A};
        tbl[1]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h31};
        tbl[2]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 8'h7A, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};
        tbl[6]  = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 8'h7B, 1'b1, 1'b1, 1'b1, 1'b1, 8'h31};
        tbl[8]  = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h31};
        tbl[11] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[12] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 8'h7A};
        tbl[13] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 8'h7A};
        tbl[14] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[15] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h23};
        for (int i = 0; i < 17; i++) begin
            drive(1, tbl[i].st, tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].chk,
                  16'(tbl[i].exp), tbl[i].want);
        end
        idle();
        chk("b_busy_done", 32'(b_busy), 0);
        chk("b_state_final", 32'(b_state), 32'h23);

        // Random multi-beat frames against the serial reference
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, 4);
            m = 8'h00;
            for (int j = 0; j < n; j++) begin
                d = 8'($urandom);
                m = ref8(m, d);
                drive(1, j == 0, d, 1, j == n - 1, 0, 16'(m), j == n - 1);
                if (j != n - 1 && $urandom_range(0, 2) == 0) idle();
            end
        end

        // Serial 0x80 with idle gaps between bits
        for (int i = 7; i >= 0; i--) begin
            drive(0, i == 7, 8'(i == 7), 1, i == 0, 0, 16'h7A, i == 0);
            if (i == 6 || i == 4 || i == 2) idle();
        end
        idle();

        // CRC-16/CCITT-FALSE over "123456789"
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        for (int i = 0; i < 9; i++) begin
            drive(2, i == 0, msg[i], 1, i == 8, 0, 16'h29B1, i == 8);
        end
        idle();
        idle();
        chk("w_busy_done", 32'(w_busy), 0);

        // Reset in the middle of a serial frame
        drive(0, 1, 8'h01, 1, 0, 0, 16'h0, 0);
        drive(0, 0, 8'h00, 1, 0, 0, 16'h0, 0);
        chk("s_busy_mid", 32'(s_busy), 1);
        #2;
        rstn = 0;
        #1;
        chk("mid_s_busy", 32'(s_busy), 0);   chk("mid_s_out", 32'(s_out), 0);
        chk("mid_s_vld", 32'(s_cv), 0);      chk("mid_s_state", 32'(s_state), 0);
        chk("mid_b_out", 32'(b_out), 0);     chk("mid_w_out", 32'(w_out), 0);
        chk("mid_w_state", 32'(w_state), 32'hFFFF);
        s_start = 0; s_valid = 0; s_last = 0; s_din = '0;
        #3;
        rstn = 1;
        idle();
        chk("post_rst_busy", 32'(s_busy), 0);
        for (int i = 7; i >= 0; i--) begin
            drive(0, i == 7, 8'(i == 0), 1, i == 0, 0, 16'h31, i == 0);
        end
        for (int i = 0; i < 4; i++) idle();

        chk("sq_drained", 32'(sq.size()), 0);
        chk("bq_drained", 32'(bq.size()), 0);
        chk("wq_drained", 32'(wq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
